// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Registered program counter and fetch sequencer for the
//            multi-cycle core. Requests one instruction word at a time from
//            instruction memory and holds it for the decoder until the core
//            retires it. On retire it resolves the next PC (branch > jump >
//            sequential). It raises a sticky fault on fetch timeout, on a
//            misaligned target or on an illegal branch type.
// Option   : `define PC_SEQ_PERF_EN adds o_perf_retired / o_perf_taken.
// Ports    : clk, rst (sync, active-low)
//            o_imem_req/o_imem_addr/i_imem_rdata/i_imem_valid - fetch handshake
//            o_inst/o_inst_valid/o_pc/o_pc_plus4              - to decoder
//            i_stall/i_retire                                 - advance control
//            i_branch/i_branch_type/i_zero/i_less/i_imm       - branch resolve
//            i_jump/i_jump_target                             - jump resolve
//            o_fault/o_fault_code/o_fault_pc                  - sticky fault
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              MAX_WAIT     = 16,
  parameter int              BR_SHIFT     = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_imem_valid,
  output logic [31:0]     o_inst,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  input  logic            i_stall,
  input  logic            i_retire,
  input  logic            i_branch,
  input  logic [2:0]      i_branch_type,
  input  logic            i_zero,
  input  logic            i_less,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_fault,
  output logic [1:0]      o_fault_code,
  output logic [XLEN-1:0] o_fault_pc
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]     o_perf_retired,
  output logic [31:0]     o_perf_taken
`endif
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] c_WAIT_LAST = CW'(MAX_WAIT - 1);

  localparam logic [1:0] c_FC_TIMEOUT = 2'b01;
  localparam logic [1:0] c_FC_MISALGN = 2'b10;
  localparam logic [1:0] c_FC_ILLBR   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [CW-1:0]   r_wait_cnt;
  logic [CW-1:0]   w_wait_cnt_n;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic            r_fault;
  logic [1:0]      r_fault_code;
  logic [XLEN-1:0] r_fault_pc;

  logic            w_imem_req;
  logic            w_inst_valid;
  logic            w_load_inst;
  logic            w_pc_load;
  logic            w_fault_set;
  logic [1:0]      w_fault_code_n;
  logic [XLEN-1:0] w_fault_pc_n;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_br_target;
  logic            w_br_cond;
  logic            w_br_illegal;
  logic [XLEN-1:0] w_next_pc;
  logic            w_taken;
  logic            w_advance;

  // --------------------------------------------------------------------------
  // Next-PC resolution
  // --------------------------------------------------------------------------
  assign w_pc_plus4  = r_pc + XLEN'(4);
  assign w_br_target = r_pc + (i_imm << BR_SHIFT);

  always_comb begin
    w_br_cond    = 1'b0;
    w_br_illegal = 1'b0;
    case (i_branch_type)
      3'b000:          w_br_cond = i_zero;
      3'b001:          w_br_cond = ~i_zero;
      3'b100, 3'b110:  w_br_cond = i_less;
      3'b101, 3'b111:  w_br_cond = ~i_less;
      default:         w_br_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_next_pc = w_pc_plus4;
    w_taken   = 1'b0;
    if (i_branch) begin
      if (w_br_cond) begin
        w_next_pc = w_br_target;
        w_taken   = 1'b1;
      end
    end else if (i_jump) begin
      w_next_pc = i_jump_target;
      w_taken   = 1'b1;
    end
  end

  // stall wins over retire
  assign w_advance = i_retire & ~i_stall;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_n;
      r_wait_cnt <= w_wait_cnt_n;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n      = r_state;
    w_wait_cnt_n   = r_wait_cnt;
    w_imem_req     = 1'b0;
    w_inst_valid   = 1'b0;
    w_load_inst    = 1'b0;
    w_pc_load      = 1'b0;
    w_fault_set    = 1'b0;
    w_fault_code_n = 2'b00;
    w_fault_pc_n   = '0;
    case (r_state)
      S_IDLE: begin
        w_wait_cnt_n = '0;
        w_state_n    = S_FETCH;
      end
      S_FETCH: begin
        w_imem_req   = 1'b1;
        w_wait_cnt_n = '0;
        w_state_n    = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_valid) begin
          w_load_inst  = 1'b1;
          w_wait_cnt_n = '0;
          w_state_n    = S_EXEC;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          // this cycle is the MAX_WAIT-th without a response
          w_fault_set    = 1'b1;
          w_fault_code_n = c_FC_TIMEOUT;
          w_fault_pc_n   = r_pc;
          w_state_n      = S_FAULT;
        end else begin
          w_wait_cnt_n = r_wait_cnt + CW'(1);
        end
      end
      S_EXEC: begin
        w_inst_valid = 1'b1;
        if (w_advance) begin
          if (i_branch && w_br_illegal) begin
            w_fault_set    = 1'b1;
            w_fault_code_n = c_FC_ILLBR;
            w_fault_pc_n   = r_pc;
            w_state_n      = S_FAULT;
          end else if (w_next_pc[1:0] != 2'b00) begin
            // pc is left pointing at the instruction that produced the target
            w_fault_set    = 1'b1;
            w_fault_code_n = c_FC_MISALGN;
            w_fault_pc_n   = w_next_pc;
            w_state_n      = S_FAULT;
          end else begin
            w_pc_load = 1'b1;
            w_state_n = S_FETCH;
          end
        end
      end
      S_FAULT: begin
        w_state_n = S_FAULT;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc         <= RESET_VECTOR;
      r_inst       <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
      r_fault_pc   <= '0;
    end else begin
      if (w_pc_load) begin
        r_pc <= w_next_pc;
      end
      if (w_load_inst) begin
        r_inst <= i_imem_rdata;
      end
      if (w_fault_set) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_fault_code_n;
        r_fault_pc   <= w_fault_pc_n;
      end
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] r_perf_retired;
  logic [31:0] r_perf_taken;

  // counts only advances that actually move the PC; FAULT never loads pc
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_retired <= '0;
      r_perf_taken   <= '0;
    end else if (w_pc_load) begin
      r_perf_retired <= r_perf_retired + 32'd1;
      if (w_taken) begin
        r_perf_taken <= r_perf_taken + 32'd1;
      end
    end
  end

  assign o_perf_retired = r_perf_retired;
  assign o_perf_taken   = r_perf_taken;
`endif

  assign o_imem_req   = w_imem_req;
  assign o_imem_addr  = r_pc;
  assign o_inst       = r_inst;
  assign o_inst_valid = w_inst_valid;
  assign o_pc         = r_pc;
  assign o_pc_plus4   = w_pc_plus4;
  assign o_fault      = r_fault;
  assign o_fault_code = r_fault_code;
  assign o_fault_pc   = r_fault_pc;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed testbench for pc_sequencer. A small memory model answers
//            one cycle after each request with a word derived from the address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int XLEN = 32;
  localparam logic [31:0] c_KEY = 32'hC0DE_0000;

  logic            clk;
  logic            rst;
  logic            w_imem_req;
  logic [XLEN-1:0] w_imem_addr;
  logic [31:0]     r_mem_rdata;
  logic            r_mem_valid;
  logic [31:0]     w_inst;
  logic            w_inst_valid;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            r_stall;
  logic            r_retire;
  logic            r_branch;
  logic [2:0]      r_branch_type;
  logic            r_zero;
  logic            r_less;
  logic            r_jump;
  logic [XLEN-1:0] r_jump_target;
  logic [XLEN-1:0] r_imm;
  logic            w_fault;
  logic [1:0]      w_fault_code;
  logic [XLEN-1:0] w_fault_pc;
`ifdef PC_SEQ_PERF_EN
  logic [31:0]     w_perf_retired;
  logic [31:0]     w_perf_taken;
`endif

  logic            r_mem_en;
  int              r_req_cnt;
  logic [31:0]     r_last_req_addr;
  int              errors;
  int              checks;

  pc_sequencer #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_0000),
    .MAX_WAIT     (4),
    .BR_SHIFT     (1)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .o_imem_req    (w_imem_req),
    .o_imem_addr   (w_imem_addr),
    .i_imem_rdata  (r_mem_rdata),
    .i_imem_valid  (r_mem_valid),
    .o_inst        (w_inst),
    .o_inst_valid  (w_inst_valid),
    .o_pc          (w_pc),
    .o_pc_plus4    (w_pc_plus4),
    .i_stall       (r_stall),
    .i_retire      (r_retire),
    .i_branch      (r_branch),
    .i_branch_type (r_branch_type),
    .i_zero        (r_zero),
    .i_less        (r_less),
    .i_jump        (r_jump),
    .i_jump_target (r_jump_target),
    .i_imm         (r_imm),
    .o_fault       (w_fault),
    .o_fault_code  (w_fault_code),
    .o_fault_pc    (w_fault_pc)
`ifdef PC_SEQ_PERF_EN
    ,
    .o_perf_retired(w_perf_retired),
    .o_perf_taken  (w_perf_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory answers the cycle after a request
  always @(posedge clk) begin
    r_mem_valid <= w_imem_req & r_mem_en;
    r_mem_rdata <= w_imem_addr ^ c_KEY;
    if (w_imem_req) begin
      r_req_cnt       <= r_req_cnt + 1;
      r_last_req_addr <= w_imem_addr;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic clear_inputs();
    r_stall       = 1'b0;
    r_retire      = 1'b0;
    r_branch      = 1'b0;
    r_branch_type = 3'b000;
    r_zero        = 1'b0;
    r_less        = 1'b0;
    r_jump        = 1'b0;
    r_jump_target = '0;
    r_imm         = '0;
  endtask

  task automatic wait_exec(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (!w_inst_valid) tick();
    end
    check_eq(tag, {31'd0, w_inst_valid}, 32'd1);
  endtask

  task automatic do_retire(input logic br, input logic [2:0] bt, input logic z,
                           input logic l, input logic j, input logic [31:0] jt,
                           input logic [31:0] im);
    r_branch      = br;
    r_branch_type = bt;
    r_zero        = z;
    r_less        = l;
    r_jump        = j;
    r_jump_target = jt;
    r_imm         = im;
    r_retire      = 1'b1;
    tick();
    clear_inputs();
  endtask

  int saved_req;

  initial begin
    errors    = 0;
    checks    = 0;
    r_mem_en  = 1'b1;
    r_req_cnt = 0;
    r_last_req_addr = '0;
    r_mem_valid = 1'b0;
    r_mem_rdata = '0;
    clear_inputs();

    // ---- reset state and first fetch ------------------------------------
    rst = 1'b0;
    tick();
    check_eq("rst_pc",     w_pc, 32'h0);
    check_eq("rst_inst",   w_inst, 32'h0);
    check_eq("rst_ivalid", {31'd0, w_inst_valid}, 32'd0);
    check_eq("rst_fault",  {31'd0, w_fault}, 32'd0);
    check_eq("rst_plus4",  w_pc_plus4, 32'h4);
    rst = 1'b1;
    check_eq("c1_req",     {31'd0, w_imem_req}, 32'd0);
    tick();
    check_eq("c2_req",     {31'd0, w_imem_req}, 32'd1);
    check_eq("c2_addr",    w_imem_addr, 32'h0);
    tick();
    check_eq("c3_req",     {31'd0, w_imem_req}, 32'd0);
    check_eq("c3_ivalid",  {31'd0, w_inst_valid}, 32'd0);
    tick();
    check_eq("c4_ivalid",  {31'd0, w_inst_valid}, 32'd1);
    check_eq("c4_inst",    w_inst, 32'h0 ^ c_KEY);

    // ---- jump to 0x10, beq taken -> 0x18 ---------------------------------
    do_retire(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0);
    wait_exec("exec_j10");
    check_eq("pc_j10",   w_pc, 32'h10);
    check_eq("inst_j10", w_inst, 32'h10 ^ c_KEY);
    do_retire(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4);
    check_eq("beq_t_addr", w_imem_addr, 32'h18);
    wait_exec("exec_beq_t");
    check_eq("beq_t_pc", w_pc, 32'h18);

    // ---- back to 0x10, beq not taken -> 0x14 -----------------------------
    do_retire(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0);
    wait_exec("exec_j10b");
    do_retire(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
    wait_exec("exec_beq_nt");
    check_eq("beq_nt_pc",   w_pc, 32'h14);
    check_eq("beq_nt_last", r_last_req_addr, 32'h14);

    // ---- stall holds the instruction --------------------------------------
    saved_req = r_req_cnt;
    r_retire  = 1'b1;
    r_stall   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_pc",     w_pc, 32'h14);
      check_eq("stall_ivalid", {31'd0, w_inst_valid}, 32'd1);
      check_eq("stall_req",    {31'd0, w_imem_req}, 32'd0);
    end
    check_eq("stall_inst",   w_inst, 32'h14 ^ c_KEY);
    check_eq("stall_reqcnt", r_req_cnt, saved_req);
    r_stall = 1'b0;
    tick();
    clear_inputs();
    check_eq("unstall_req",  {31'd0, w_imem_req}, 32'd1);
    check_eq("unstall_addr", w_imem_addr, 32'h18);
    wait_exec("exec_unstall");
    check_eq("unstall_pc",   w_pc, 32'h18);

    // ---- other branch types ----------------------------------------------
    // bge, !less, imm=-2 -> 0x18 - 4 = 0x14
    do_retire(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFE);
    wait_exec("exec_bge");
    check_eq("bge_pc", w_pc, 32'h14);
    // blt with less=0 -> not taken
    do_retire(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40);
    wait_exec("exec_blt");
    check_eq("blt_nt_pc", w_pc, 32'h18);
    // bne taken, branch beats jump: 0x18 + 0x20 = 0x38
    do_retire(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 32'h100, 32'h10);
    wait_exec("exec_bne");
    check_eq("bne_pc", w_pc, 32'h38);

    // ---- sequential wrap then illegal branch ------------------------------
    do_retire(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    wait_exec("exec_top");
    check_eq("top_pc",    w_pc, 32'hFFFF_FFFC);
    check_eq("top_plus4", w_pc_plus4, 32'h0);
    do_retire(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_exec("exec_wrap");
    check_eq("wrap_pc",    w_pc, 32'h0);
    check_eq("wrap_fault", {31'd0, w_fault}, 32'd0);
    do_retire(1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4);
    check_eq("ill_fault",  {31'd0, w_fault}, 32'd1);
    check_eq("ill_code",   {30'd0, w_fault_code}, 32'd3);
    check_eq("ill_fpc",    w_fault_pc, 32'h0);
    check_eq("ill_ivalid", {31'd0, w_inst_valid}, 32'd0);

    // ---- misaligned jump target -------------------------------------------
    do_reset();
    wait_exec("exec_rst2");
    do_retire(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
    wait_exec("exec_j20");
    do_retire(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h102, 32'h0);
    saved_req = r_req_cnt;
    check_eq("mis_fault", {31'd0, w_fault}, 32'd1);
    check_eq("mis_code",  {30'd0, w_fault_code}, 32'd2);
    check_eq("mis_fpc",   w_fault_pc, 32'h102);
    check_eq("mis_pc",    w_pc, 32'h20);
    r_retire = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    r_retire = 1'b0;
    check_eq("mis_noreq",  r_req_cnt, saved_req);
    check_eq("mis_sticky", {31'd0, w_fault}, 32'd1);
    check_eq("mis_pc2",    w_pc, 32'h20);

    // ---- fetch timeout: MAX_WAIT=4 ----------------------------------------
    r_mem_en = 1'b0;
    do_reset();
    check_eq("to_cleared", {31'd0, w_fault}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("to_early", {31'd0, w_fault}, 32'd0);
    tick();
    check_eq("to_fault", {31'd0, w_fault}, 32'd1);
    check_eq("to_code",  {30'd0, w_fault_code}, 32'd1);
    check_eq("to_fpc",   w_fault_pc, 32'h0);
    r_mem_en = 1'b1;
    do_reset();
    check_eq("to_rst_fault", {31'd0, w_fault}, 32'd0);
    check_eq("to_rst_pc",    w_pc, 32'h0);
    tick();
    check_eq("to_refetch",   {31'd0, w_imem_req}, 32'd1);
    check_eq("to_refaddr",   w_imem_addr, 32'h0);
    wait_exec("exec_after_to");
    check_eq("to_inst",      w_inst, 32'h0 ^ c_KEY);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered program-counter and fetch sequencer for the multi-cycle core generation. It replaces the inline combinational next-PC logic of the single-cycle top level. The block owns the PC and drives a request/valid handshake to instruction memory. It holds the fetched instruction until the core retires it, then resolves branch/jump redirection. It sits between instruction memory and the decoder/controller, and it flags fetch timeouts, misaligned targets and illegal branch types.

Parameters:
XLEN, 32, PC/address/immediate width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 16, cycles in WAIT without imem_valid before a timeout fault (>=1)
BR_SHIFT, 1, left shift applied to imm for branch offset (decoder emits halved offset)

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-low
imem_req  out  1  fetch request, one-cycle pulse
imem_addr  out  XLEN  fetch address (= pc)
imem_rdata  in  32  instruction word
imem_valid  in  1  imem_rdata valid
inst  out  32  held instruction for decoder
inst_valid  out  1  inst is valid (EXEC state)
pc  out  XLEN  address of held instruction
pc_plus4  out  XLEN  pc+4 (link value)
stall  in  1  core not finished; blocks advance
retire  in  1  current instruction completes this cycle
branch  in  1  instruction is conditional branch
branch_type  in  3  funct3 encoding of the branch
zero  in  1  ALU equal flag
less  in  1  ALU less-than flag (signed/unsigned chosen by ALU)
jump  in  1  instruction is JAL/JALR
jump_target  in  XLEN  ALU-computed jump target
imm  in  XLEN  sign-extended branch immediate
fault  out  1  sticky fault flag
fault_code  out  2  01 timeout, 10 misaligned target, 11 illegal branch_type
fault_pc  out  XLEN  offending address (fetch addr or bad target)

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; pc=RESET_VECTOR; inst=0; all other outputs=0; wait counter=0.
- States:
  - IDLE: unconditional transition to FETCH.
  - FETCH: imem_req=1 for one cycle; next state WAIT. imem_valid is ignored in FETCH.
  - WAIT: the wait counter increments each cycle. On imem_valid, inst<=imem_rdata and go to EXEC (counter cleared). If the counter reaches MAX_WAIT without imem_valid, go to FAULT with code 01 and fault_pc=pc.
  - EXEC: inst_valid=1. The block advances only when retire=1 and stall=0; stall has priority over retire. On advance, pc<=next_pc and the state goes to FETCH.
  - FAULT: sticky. inst_valid=0, imem_req=0, pc frozen. Only reset exits this state.
- next_pc resolution, priority branch > jump > sequential:
  - beq 000: taken on zero.
  - bne 001: taken on !zero.
  - blt 100 / bltu 110: taken on less.
  - bge 101 / bgeu 111: taken on !less.
  - Taken target = pc + (imm<<BR_SHIFT). Not taken = pc+4.
  - branch=1 with branch_type 010 or 011: FAULT with code 11 and fault_pc=pc.
  - jump=1: jump_target.
  - Otherwise: pc+4.
- All additions are modulo 2^XLEN; wrap-around is silent.
- If next_pc[1:0]!=0 on advance: FAULT with code 10 and fault_pc=next_pc; pc is not updated.
- Minimum CPI is 3 (EXEC, FETCH, WAIT) when memory answers the cycle after the request.
- Reset during WAIT or EXEC aborts the access. A late imem_valid after reset is ignored because the state is IDLE/FETCH.
- pc_plus4 is combinational from pc.
- retire outside EXEC is ignored.

Optional Feature:
PC_SEQ_PERF_EN
- Defined: adds the outputs perf_retired[31:0] and perf_taken[31:0]. perf_retired increments on each EXEC advance. perf_taken increments when the advance takes a branch or jump. Both are cleared on reset and wrap at 2^32, and both freeze in FAULT.
- Undefined: these ports and counters do not exist, and there is no other behavioural difference.

Test Plan:
- Reset release with memory answering 1 cycle after the request -> imem_req pulses at cycle 2 with imem_addr=0x0; inst_valid=1 at cycle 4; inst equals the memory word.
- pc=0x10, branch=1, branch_type=000, zero=1, imm=0x4, retire -> next fetch at 0x18. Same with zero=0 -> fetch at 0x14.
- pc=0x20, jump=1, jump_target=0x102 on retire -> fault=1, fault_code=10, fault_pc=0x102, pc stays 0x20, no further imem_req.
- MAX_WAIT=4 and imem_valid never asserted -> after 4 WAIT cycles fault=1, code=01, fault_pc=current pc. Asserting rst=0 for one edge clears it and the fetch restarts at RESET_VECTOR.
- In EXEC, retire=1 with stall=1 for 3 cycles -> pc and inst are unchanged and no imem_req. Then stall=0 -> advance to pc+4.
- pc=0xFFFF_FFFC, sequential retire -> next fetch at 0x0000_0000 with no fault. branch_type=011 with branch=1 -> fault code 11.
